muldiv_issue_ctrl: RTL and testbench

//  Execute-stage requester for the multi-cycle mul/div unit.
//  - Accepts an M-extension op from EX and registers its operands.
//  - Pulses start and holds the request stable until the unit responds.
//  - Stalls the pipeline while busy, then presents the result until the EX/MEM register accepts it.
//  - Resolves RISC-V divide special cases locally (no unit request) and drains squashed in-flight ops.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 23 ++
 rtl/muldiv_special_case.sv | 34 +++
 rtl/muldiv_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mul/div issue controller.
package muldiv_pkg;

  // M-extension operation encoding as presented by EX.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  // Issue controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mdctl_state_t;

  // Quotient of a divide by zero, and the most negative 32-bit integer.
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Divide/remainder ops occupy the upper half of the encoding.
  function automatic logic is_div_op(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bus between the issue controller and the mul/div unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic        md_start;
  muldiv_op_t  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_resp;
  logic [31:0] md_result;

  // Requester side: drives the request, receives the result.
  modport master (
    output md_start, md_op, md_a, md_b,
    input  md_resp, md_result
  );

  // Unit side: receives the request, drives the result.
  modport slave (
    input  md_start, md_op, md_a, md_b,
    output md_resp, md_result
  );
endinterface

// File: rtl/muldiv_special_case.sv
// Detects RISC-V divide corner cases whose result is fixed by the ISA,
// so the controller can answer them without occupying the unit.
module muldiv_special_case
  import muldiv_pkg::*;
(
  input  muldiv_op_t  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_hit,
  output logic [31:0] o_value
);

  // Divide-by-zero takes precedence over signed overflow.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    o_hit   = 1'b0;
    o_value = '0;
    if (is_div_op(i_op)) begin
      if (i_b == '0) begin
        o_hit   = 1'b1;
        o_value = (i_op == OP_DIV || i_op == OP_DIVU) ? DIV_ZERO_Q : i_a;
      end else if (i_a == INT_MIN && i_b == 32'hFFFF_FFFF) begin
        if (i_op == OP_DIV) begin
          o_hit   = 1'b1;
          o_value = INT_MIN;
        end else if (i_op == OP_REM) begin
          o_hit   = 1'b1;
          o_value = '0;
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Execute-stage requester for the multi-cycle mul/div unit: registers the
// operands, pulses start, stalls EX while the unit works, presents the
// result until EX/MEM takes it, and drains responses of squashed ops.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int MAX_LAT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  muldiv_op_t  ex_op,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  input  logic        wb_ready,
  output logic        stall_o,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        err_timeout,
  muldiv_if.master    md
);

  localparam int                CNT_W    = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_LAT - 1);

  mdctl_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_start;
  muldiv_op_t       r_md_op;
  logic [31:0]      r_md_a;
  logic [31:0]      r_md_b;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic [4:0]       r_res_rd;
  logic             r_err_timeout;

  logic             w_accept;
  logic             w_sc_hit;
  logic [31:0]      w_sc_value;

  muldiv_special_case u_special (
    .i_op    (ex_op),
    .i_a     (ex_rs1),
    .i_b     (ex_rs2),
    .o_hit   (w_sc_hit),
    .o_value (w_sc_value)
  );

  assign w_accept = ex_valid & ~flush;

  // Controller FSM with registered request and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_md_start    <= 1'b0;
      r_md_op       <= OP_MUL;
      r_md_a        <= '0;
      r_md_b        <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_rd      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every branch sees pre-edge values.
      r_md_start <= 1'b0;  // start is a single-cycle pulse
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_res_rd <= ex_rd;
            if (w_sc_hit) begin
              r_res_data  <= w_sc_value;
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_md_op    <= ex_op;
              r_md_a     <= ex_rs1;
              r_md_b     <= ex_rs2;
              r_md_start <= 1'b1;
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt <= '0;
          if (md.md_resp) begin
            r_res_data  <= md.md_result;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (md.md_resp) begin
            r_res_data  <= md.md_result;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end else if (r_cnt == CNT_LAST) begin
            // Unit never answered: hand off a zero result and flag it.
            r_cnt         <= CNT_MAX;
            r_err_timeout <= 1'b1;
            r_res_data    <= '0;
            r_res_valid   <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (wb_ready || flush) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (md.md_resp) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Hold the front end while an accepted M-op has not been handed off.
  assign stall_o = ex_valid & ~flush & ~((r_state == ST_DONE) & wb_ready);

  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_rd       = r_res_rd;
  assign err_timeout  = r_err_timeout;
  assign md.md_start  = r_md_start;
  assign md.md_op     = r_md_op;
  assign md.md_a      = r_md_a;
  assign md.md_b      = r_md_b;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl; the bench plays the mul/div unit.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  localparam int MAX_LAT = 8;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    bit          special;  // answered locally, no unit request
    int          delay;    // unit response cycles after start; -1 = never
    logic [31:0] res;      // expected result (also what the unit returns)
    int          hold;     // cycles with wb_ready low once DONE
    bit          err;      // expected err_timeout after handoff
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  muldiv_op_t  ex_op;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        wb_ready;
  logic        stall_o;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        err_timeout;

  muldiv_if md_bus();

  muldiv_issue_ctrl #(.MAX_LAT(MAX_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .wb_ready    (wb_ready),
    .stall_o     (stall_o),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .err_timeout (err_timeout),
    .md          (md_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the start pulse; called at a negedge.
  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      seen = md_bus.md_start;
    end
    check({tag, " start seen"}, 32'(seen), 32'd1);
  endtask

  // Present one op in EX, act as the unit, then retire it through wb_ready.
  task automatic run_op(input vec_t v, input string tag);
    int starts  = 0;
    int since   = -1;
    int lat     = 0;
    bit got     = 1'b0;
    int exp_lat = v.special ? 1 : ((v.delay < 0) ? MAX_LAT + 2 : v.delay + 2);
    ex_valid = 1'b1; ex_op = v.op; ex_rs1 = v.a; ex_rs2 = v.b; ex_rd = v.rd;
    wb_ready = 1'b0; flush = 1'b0;
    #1;
    check({tag, " stall on entry"}, 32'(stall_o), 32'd1);
    while (!got && lat < 64) begin
      @(negedge clk);
      lat++;
      md_bus.md_resp = 1'b0;
      if (md_bus.md_start) begin
        starts++;
        since = 0;
        check({tag, " md_a"}, md_bus.md_a, v.a);
        check({tag, " md_b"}, md_bus.md_b, v.b);
        check({tag, " md_op"}, 32'(md_bus.md_op), 32'(v.op));
      end else if (since >= 0) begin
        since++;
      end
      if (res_valid) got = 1'b1;
      else if (since >= 0 && since == v.delay) begin
        md_bus.md_resp   = 1'b1;
        md_bus.md_result = v.res;
      end
    end
    check({tag, " result arrived"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " start pulses"}, 32'(starts), v.special ? 32'd0 : 32'd1);
    check({tag, " res_data"}, res_data, v.res);
    check({tag, " res_rd"}, 32'(res_rd), 32'(v.rd));
    check({tag, " err_timeout"}, 32'(err_timeout), 32'(v.err));
    check({tag, " stall in DONE"}, 32'(stall_o), 32'd1);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(res_valid), 32'd1);
      check({tag, " hold data"}, res_data, v.res);
      check({tag, " hold rd"}, 32'(res_rd), 32'(v.rd));
      check({tag, " hold stall"}, 32'(stall_o), 32'd1);
    end
    wb_ready = 1'b1;
    #1;
    check({tag, " stall released"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    wb_ready = 1'b0;
    ex_valid = 1'b0;
    check({tag, " valid dropped"}, 32'(res_valid), 32'd0);
  endtask

  vec_t vecs[13];
  vec_t v_tmp;

  initial begin
    // op, a, b, rd, special, delay, res, hold, err
    vecs[0]  = '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  1'b0, 3,  32'hFFFF_FFEB, 0, 1'b0};
    vecs[1]  = '{OP_DIVU,   32'd5,         32'd0,         5'd6,  1'b1, 0,  32'hFFFF_FFFF, 0, 1'b0};
    vecs[2]  = '{OP_REM,    32'hFFFF_FFF9, 32'd0,         5'd7,  1'b1, 0,  32'hFFFF_FFF9, 0, 1'b0};
    vecs[3]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  1'b1, 0,  32'h8000_0000, 0, 1'b0};
    vecs[4]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  1'b1, 0,  32'h0000_0000, 0, 1'b0};
    vecs[5]  = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, 2,  32'h0000_0000, 0, 1'b0};
    vecs[6]  = '{OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, 0,  32'h8000_0000, 0, 1'b0};
    vecs[7]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0, 1,  32'hFFFF_FFFE, 4, 1'b0};
    vecs[8]  = '{OP_MUL,    32'd5,         32'd0,         5'd13, 1'b0, 1,  32'h0000_0000, 0, 1'b0};
    vecs[9]  = '{OP_DIV,    32'h8000_0000, 32'd0,         5'd14, 1'b1, 0,  32'hFFFF_FFFF, 0, 1'b0};
    vecs[10] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd15, 1'b0, 4,  32'h4000_0000, 0, 1'b0};
    vecs[11] = '{OP_DIV,    32'd100,       32'd7,         5'd16, 1'b0, 8,  32'h0000_000E, 0, 1'b0};
    vecs[12] = '{OP_DIVU,   32'd1234,      32'd1,         5'd17, 1'b0, -1, 32'h0000_0000, 0, 1'b1};

    rst = 1'b0; ex_valid = 1'b0; ex_op = OP_MUL; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    flush = 1'b0; wb_ready = 1'b0; md_bus.md_resp = 1'b0; md_bus.md_result = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data", res_data, 32'd0);
    check("rst res_rd", 32'(res_rd), 32'd0);
    check("rst md_start", 32'(md_bus.md_start), 32'd0);
    check("rst md_a", md_bus.md_a, 32'd0);
    check("rst md_b", md_bus.md_b, 32'd0);
    check("rst err", 32'(err_timeout), 32'd0);
    check("rst stall", 32'(stall_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Flush while waiting: drain the late response, queued op held off until IDLE.
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 32'd20; ex_rs2 = 32'd3; ex_rd = 5'd3;
    wait_start("drain");
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ex_op = OP_DIVU; ex_rs1 = 32'd9; ex_rs2 = 32'd0; ex_rd = 5'd20;
    #1;
    check("drain stall", 32'(stall_o), 32'd1);
    for (int c = 0; c < 4; c++) begin
      check("drain quiet", {30'd0, res_valid, md_bus.md_start}, 32'd0);
      @(negedge clk);
    end
    check("drain quiet", {30'd0, res_valid, md_bus.md_start}, 32'd0);
    md_bus.md_resp = 1'b1; md_bus.md_result = 32'hBAD0_BAD0;
    @(negedge clk);
    md_bus.md_resp = 1'b0;
    check("drain discarded", 32'(res_valid), 32'd0);
    v_tmp = '{OP_DIVU, 32'd9, 32'd0, 5'd20, 1'b1, 0, 32'hFFFF_FFFF, 0, 1'b0};
    run_op(v_tmp, "queued");

    // Response and flush in the same cycle: result captured, flush then drops it.
    ex_valid = 1'b1; ex_op = OP_MUL; ex_rs1 = 32'd6; ex_rs2 = 32'd7; ex_rd = 5'd9;
    wait_start("resp+flush");
    @(negedge clk);
    md_bus.md_resp = 1'b1; md_bus.md_result = 32'd42; flush = 1'b1;
    @(negedge clk);
    md_bus.md_resp = 1'b0;
    check("resp+flush valid", 32'(res_valid), 32'd1);
    check("resp+flush data", res_data, 32'd42);
    check("resp+flush stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0;
    check("resp+flush dropped", 32'(res_valid), 32'd0);

    // Table of ops, back to back; ends with the timeout case.
    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));
    check("err sticky", 32'(err_timeout), 32'd1);

    // Reset while waiting on the unit; a late response must be ignored.
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 32'd50; ex_rs2 = 32'd5; ex_rd = 5'd21;
    wait_start("midrst");
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0;
    #1;
    check("midrst res_valid", 32'(res_valid), 32'd0);
    check("midrst res_data", res_data, 32'd0);
    check("midrst res_rd", 32'(res_rd), 32'd0);
    check("midrst md_start", 32'(md_bus.md_start), 32'd0);
    check("midrst md_a", md_bus.md_a, 32'd0);
    check("midrst md_b", md_bus.md_b, 32'd0);
    check("midrst md_op", 32'(md_bus.md_op), 32'd0);
    check("midrst err", 32'(err_timeout), 32'd0);
    check("midrst stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    md_bus.md_resp = 1'b1; md_bus.md_result = 32'd10;
    @(negedge clk);
    md_bus.md_resp = 1'b0;
    check("late resp ignored", {30'd0, res_valid, md_bus.md_start}, 32'd0);
    v_tmp = '{OP_MUL, 32'd3, 32'd4, 5'd22, 1'b0, 2, 32'd12, 0, 1'b0};
    run_op(v_tmp, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
